pip_ma_lsu: RTL and testbench

PIP_MA_LSU -- requirements
Module: pip_ma_lsu

---
 rtl/pip_rv32_pkg.sv | 41 ++++
 rtl/pip_ma_align.sv | 56 +++++
 rtl/pip_ma_lsu.sv | 117 +++++++++++
 tb/tb_pip_ma_lsu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pip_rv32_pkg.sv
// rtl/pip_rv32_pkg.sv - load/store funct3 codes, LSU state encoding, access legality helper
package pip_rv32_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsuState_e;

  // Undefined encodings fold into the misaligned exception path alongside real misalignment.
  function automatic logic accessOk(input logic isLoad, input logic [2:0] funct3,
                                    input logic [2:0] off, input logic is64);
    logic legal;
    logic aligned;
    if (isLoad)
      legal = (funct3 == LB) | (funct3 == LH) | (funct3 == LW) | (funct3 == LBU) |
              (funct3 == LHU) | (is64 & ((funct3 == LD) | (funct3 == LWU)));
    else
      legal = (funct3 == SB) | (funct3 == SH) | (funct3 == SW) | (is64 & (funct3 == SD));
    case (funct3[1:0])
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~off[0];
      2'd2:    aligned = ~|off[1:0];
      default: aligned = ~|off;
    endcase
    return legal & aligned;
  endfunction

endpackage

// File: rtl/pip_ma_align.sv
// rtl/pip_ma_align.sv - byte-enable/store replication and load lane extract/extend
module pip_ma_align
  import pip_rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [2:0]        off,
  input  logic [XLEN-1:0]   stData,
  input  logic [XLEN-1:0]   rdData,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   ldData
);

  localparam int BW = XLEN / 8;

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic [BW-1:0]   beBase;
  logic            signBit;

  assign shifted = rdData >> {off, 3'b000};

  always_comb begin
    beBase  = '1;
    mask    = '1;
    signBit = 1'b0;
    wdata   = stData;
    case (funct3[1:0])
      2'd0: begin
        beBase  = BW'(8'h01);
        mask    = XLEN'(64'hFF);
        signBit = shifted[7];
        wdata   = {BW{stData[7:0]}};
      end
      2'd1: begin
        beBase  = BW'(8'h03);
        mask    = XLEN'(64'hFFFF);
        signBit = shifted[15];
        wdata   = {(XLEN/16){stData[15:0]}};
      end
      2'd2: begin
        beBase  = BW'(8'h0F);
        mask    = XLEN'(64'hFFFF_FFFF);
        signBit = shifted[31];
        wdata   = {(XLEN/32){stData[31:0]}};
      end
      default: ;
    endcase
    be = beBase << off;
    // funct3[2] marks the unsigned load variants.
    ldData = (shifted & mask) | ((signBit & ~funct3[2]) ? ~mask : '0);
  end

endmodule

// File: rtl/pip_ma_lsu.sv
// rtl/pip_ma_lsu.sv - memory-access stage load/store unit with single outstanding request
module pip_ma_lsu
  import pip_rv32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iValid,
  input  logic                iMEM,
  input  logic                iRW,
  input  logic [2:0]          iFUNCT3,
  input  logic [ADDR_W-1:0]   iADDR,
  input  logic [XLEN-1:0]     iSTDATA,
  input  logic [4:0]          iDregADDR,
  input  logic [XLEN-1:0]     iDregDATA,
  output logic                oStall,
  output logic                oValid,
  output logic [4:0]          oDregADDR,
  output logic [XLEN-1:0]     oDregDATA,
  output logic                oMisalign,
  output logic                oDReq,
  output logic                oDWe,
  output logic [ADDR_W-1:0]   oDAddr,
  output logic [XLEN/8-1:0]   oDBe,
  output logic [XLEN-1:0]     oDWdata,
  input  logic                iDAck,
  input  logic [XLEN-1:0]     iDRdata
);

  localparam int OFFW = (XLEN == 64) ? 3 : 2;

  lsuState_e         state;
  logic [2:0]        capFunct3, capOff, inOff, alignF3, alignOff;
  logic [4:0]        capRd;
  logic              capLoad, memOk, accept;
  logic [XLEN/8-1:0] alignBe;
  logic [XLEN-1:0]   alignWdata, alignLd;

  assign inOff    = 3'(iADDR[OFFW-1:0]);
  assign memOk    = accessOk(iRW, iFUNCT3, inOff, XLEN == 64);
  assign accept   = (state == IDLE) & iValid & iMEM & memOk;
  assign oStall   = (state == WAIT) | accept;
  assign alignF3  = (state == WAIT) ? capFunct3 : iFUNCT3;
  assign alignOff = (state == WAIT) ? capOff : inOff;

  pip_ma_align #(.XLEN(XLEN)) uAlign (
    .funct3(alignF3),
    .off   (alignOff),
    .stData(iSTDATA),
    .rdData(iDRdata),
    .be    (alignBe),
    .wdata (alignWdata),
    .ldData(alignLd)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      oValid    <= 1'b0;
      oDregADDR <= '0;
      oDregDATA <= '0;
      oMisalign <= 1'b0;
      oDReq     <= 1'b0;
      oDWe      <= 1'b0;
      oDAddr    <= '0;
      oDBe      <= '0;
      oDWdata   <= '0;
      capFunct3 <= '0;
      capOff    <= '0;
      capRd     <= '0;
      capLoad   <= 1'b0;
    end else begin
      oValid    <= 1'b0;
      oMisalign <= 1'b0;
      case (state)
        IDLE: begin
          if (iValid && !iMEM) begin
            oValid    <= 1'b1;
            oDregADDR <= iDregADDR;
            oDregDATA <= iDregDATA;
          end else if (accept) begin
            oDReq     <= 1'b1;
            oDWe      <= ~iRW;
            oDAddr    <= {iADDR[ADDR_W-1:OFFW], OFFW'(0)};
            oDBe      <= alignBe;
            oDWdata   <= alignWdata;
            capFunct3 <= iFUNCT3;
            capOff    <= inOff;
            capRd     <= iDregADDR;
            capLoad   <= iRW;
            state     <= WAIT;
          end else if (iValid) begin
            oValid    <= 1'b1;
            oMisalign <= 1'b1;
            oDregADDR <= '0;
            oDregDATA <= '0;
          end
        end
        WAIT: begin
          // Request outputs stay frozen until the memory acknowledges.
          if (iDAck) begin
            oDReq     <= 1'b0;
            oDWe      <= 1'b0;
            oValid    <= 1'b1;
            oDregADDR <= capLoad ? capRd : 5'd0;
            oDregDATA <= capLoad ? alignLd : '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pip_ma_lsu.sv
// tb/tb_pip_ma_lsu.sv - directed vector bench for pip_ma_lsu (XLEN 32 and 64 instances)
module tb_pip_ma_lsu;

  logic        iCLK, iRST;
  logic        iValid, iMEM, iRW, iDAck;
  logic [2:0]  iFUNCT3;
  logic [31:0] iADDR, iSTDATA, iDregDATA, iDRdata;
  logic [4:0]  iDregADDR;
  logic        oStall, oValid, oMisalign, oDReq, oDWe;
  logic [4:0]  oDregADDR;
  logic [31:0] oDregDATA, oDAddr, oDWdata;
  logic [3:0]  oDBe;

  logic        v64, mem64, rw64, ack64;
  logic [2:0]  f364;
  logic [31:0] addr64;
  logic [63:0] st64, dd64, rdata64;
  logic [4:0]  rd64;
  logic        stall64, oValid64, mis64, req64, we64;
  logic [4:0]  oRd64;
  logic [63:0] oData64, wd64;
  logic [31:0] dAddr64;
  logic [7:0]  be64;

  int tests = 0;
  int fails = 0;

  pip_ma_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iMEM(iMEM), .iRW(iRW),
    .iFUNCT3(iFUNCT3), .iADDR(iADDR), .iSTDATA(iSTDATA), .iDregADDR(iDregADDR),
    .iDregDATA(iDregDATA), .oStall(oStall), .oValid(oValid), .oDregADDR(oDregADDR),
    .oDregDATA(oDregDATA), .oMisalign(oMisalign), .oDReq(oDReq), .oDWe(oDWe),
    .oDAddr(oDAddr), .oDBe(oDBe), .oDWdata(oDWdata), .iDAck(iDAck), .iDRdata(iDRdata)
  );

  pip_ma_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
    .iCLK(iCLK), .iRST(iRST), .iValid(v64), .iMEM(mem64), .iRW(rw64),
    .iFUNCT3(f364), .iADDR(addr64), .iSTDATA(st64), .iDregADDR(rd64),
    .iDregDATA(dd64), .oStall(stall64), .oValid(oValid64), .oDregADDR(oRd64),
    .oDregDATA(oData64), .oMisalign(mis64), .oDReq(req64), .oDWe(we64),
    .oDAddr(dAddr64), .oDBe(be64), .oDWdata(wd64), .iDAck(ack64), .iDRdata(rdata64)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    string       name;
    logic        mem, rw;
    logic [2:0]  f3;
    logic [31:0] addr, st;
    logic [4:0]  rd;
    logic [31:0] dData, rdata;
    logic        expReq;
    logic [3:0]  expBe;
    logic [31:0] expAddr, expWd;
    logic        expMis;
    logic [4:0]  expRd;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(string nm, logic mem, logic rw, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] st, logic [4:0] rd, logic [31:0] dData, logic [31:0] rdata,
                              logic expReq, logic [3:0] expBe, logic [31:0] expAddr,
                              logic [31:0] expWd, logic expMis, logic [4:0] expRd,
                              logic [31:0] expData);
    vec_t v;
    v.name = nm; v.mem = mem; v.rw = rw; v.f3 = f3; v.addr = addr; v.st = st; v.rd = rd;
    v.dData = dData; v.rdata = rdata; v.expReq = expReq; v.expBe = expBe; v.expAddr = expAddr;
    v.expWd = expWd; v.expMis = expMis; v.expRd = expRd; v.expData = expData;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic run64(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] rdata, input logic [7:0] expBe,
                       input logic [31:0] expAddr, input logic [63:0] expData);
    v64 = 1'b1; mem64 = 1'b1; rw64 = 1'b1; f364 = f3; addr64 = addr; rd64 = 5'd12;
    #1 chk({nm, " stall"}, 64'(stall64), 64'd1);
    step();
    v64 = 1'b0; mem64 = 1'b0;
    chk({nm, " req"}, 64'(req64), 64'd1);
    chk({nm, " be"}, 64'(be64), 64'(expBe));
    chk({nm, " addr"}, 64'(dAddr64), 64'(expAddr));
    ack64 = 1'b1; rdata64 = rdata;
    step();
    ack64 = 1'b0;
    chk({nm, " valid"}, 64'(oValid64), 64'd1);
    chk({nm, " rd"}, 64'(oRd64), 64'd12);
    chk({nm, " data"}, oData64, expData);
    step();
  endtask

  initial begin
    vecs[0]  = mk("pass",    0, 0, 3'b000, 32'h0,    32'h0,        5'd5, 32'h1234, 32'h0,
                  0, 4'h0, 32'h0,    32'h0,        0, 5'd5, 32'h1234);
    vecs[1]  = mk("lb_neg",  1, 1, 3'b000, 32'h1003, 32'h0,        5'd7, 32'h0, 32'h80FFFFFF,
                  1, 4'h8, 32'h1000, 32'h0,        0, 5'd7, 32'hFFFFFF80);
    vecs[2]  = mk("lbu",     1, 1, 3'b100, 32'h1003, 32'h0,        5'd7, 32'h0, 32'h80FFFFFF,
                  1, 4'h8, 32'h1000, 32'h0,        0, 5'd7, 32'h00000080);
    vecs[3]  = mk("sh",      1, 0, 3'b001, 32'h2002, 32'hABCD,     5'd9, 32'h0, 32'h0,
                  1, 4'hC, 32'h2000, 32'hABCDABCD, 0, 5'd0, 32'h0);
    vecs[4]  = mk("lw_mis",  1, 1, 3'b010, 32'h1002, 32'h0,        5'd4, 32'h0, 32'h0,
                  0, 4'h0, 32'h0,    32'h0,        1, 5'd0, 32'h0);
    vecs[5]  = mk("lh_neg",  1, 1, 3'b001, 32'h1006, 32'h0,        5'd2, 32'h0, 32'h80010000,
                  1, 4'hC, 32'h1004, 32'h0,        0, 5'd2, 32'hFFFF8001);
    vecs[6]  = mk("lhu",     1, 1, 3'b101, 32'h1000, 32'h0,        5'd3, 32'h0, 32'h1234F00F,
                  1, 4'h3, 32'h1000, 32'h0,        0, 5'd3, 32'h0000F00F);
    vecs[7]  = mk("lw",      1, 1, 3'b010, 32'h1008, 32'h0,        5'd31, 32'h0, 32'hDEADBEEF,
                  1, 4'hF, 32'h1008, 32'h0,        0, 5'd31, 32'hDEADBEEF);
    vecs[8]  = mk("sb",      1, 0, 3'b000, 32'h3001, 32'h5A,       5'd3, 32'h0, 32'h0,
                  1, 4'h2, 32'h3000, 32'h5A5A5A5A, 0, 5'd0, 32'h0);
    vecs[9]  = mk("sw",      1, 0, 3'b010, 32'h3004, 32'hCAFEF00D, 5'd8, 32'h0, 32'h0,
                  1, 4'hF, 32'h3004, 32'hCAFEF00D, 0, 5'd0, 32'h0);
    vecs[10] = mk("ld_rv32", 1, 1, 3'b011, 32'h1000, 32'h0,        5'd6, 32'h0, 32'h0,
                  0, 4'h0, 32'h0,    32'h0,        1, 5'd0, 32'h0);
    vecs[11] = mk("sh_mis",  1, 0, 3'b001, 32'h2001, 32'h1111,     5'd6, 32'h0, 32'h0,
                  0, 4'h0, 32'h0,    32'h0,        1, 5'd0, 32'h0);
    vecs[12] = mk("ld_f7",   1, 1, 3'b111, 32'h1000, 32'h0,        5'd6, 32'h0, 32'h0,
                  0, 4'h0, 32'h0,    32'h0,        1, 5'd0, 32'h0);
    vecs[13] = mk("st_f4",   1, 0, 3'b100, 32'h3000, 32'h0,        5'd6, 32'h0, 32'h0,
                  0, 4'h0, 32'h0,    32'h0,        1, 5'd0, 32'h0);

    iRST = 1'b1; iValid = 0; iMEM = 0; iRW = 0; iFUNCT3 = 0; iADDR = 0; iSTDATA = 0;
    iDregADDR = 0; iDregDATA = 0; iDAck = 0; iDRdata = 0;
    v64 = 0; mem64 = 0; rw64 = 0; ack64 = 0; f364 = 0; addr64 = 0; st64 = 0; dd64 = 0;
    rdata64 = 0; rd64 = 0;
    step(); step();
    chk("rst valid", 64'(oValid), 64'd0);
    chk("rst req", 64'(oDReq), 64'd0);
    chk("rst be", 64'(oDBe), 64'd0);
    chk("rst rd", 64'(oDregADDR), 64'd0);
    chk("rst stall", 64'(oStall), 64'd0);
    iRST = 1'b0;
    step();

    for (int i = 0; i < 14; i++) begin
      iValid = 1'b1; iMEM = vecs[i].mem; iRW = vecs[i].rw; iFUNCT3 = vecs[i].f3;
      iADDR = vecs[i].addr; iSTDATA = vecs[i].st; iDregADDR = vecs[i].rd;
      iDregDATA = vecs[i].dData;
      #1 chk({vecs[i].name, " stall"}, 64'(oStall), 64'(vecs[i].expReq));
      step();
      iValid = 1'b0; iMEM = 1'b0;
      if (vecs[i].expReq) begin
        chk({vecs[i].name, " req"}, 64'(oDReq), 64'd1);
        chk({vecs[i].name, " we"}, 64'(oDWe), 64'(!vecs[i].rw));
        chk({vecs[i].name, " addr"}, 64'(oDAddr), 64'(vecs[i].expAddr));
        chk({vecs[i].name, " be"}, 64'(oDBe), 64'(vecs[i].expBe));
        if (!vecs[i].rw) chk({vecs[i].name, " wdata"}, 64'(oDWdata), 64'(vecs[i].expWd));
        chk({vecs[i].name, " early valid"}, 64'(oValid), 64'd0);
        iDAck = 1'b1; iDRdata = vecs[i].rdata;
        #1 chk({vecs[i].name, " ack stall"}, 64'(oStall), 64'd1);
        step();
        iDAck = 1'b0;
      end
      chk({vecs[i].name, " valid"}, 64'(oValid), 64'd1);
      chk({vecs[i].name, " mis"}, 64'(oMisalign), 64'(vecs[i].expMis));
      chk({vecs[i].name, " rd"}, 64'(oDregADDR), 64'(vecs[i].expRd));
      if (!(vecs[i].expReq && !vecs[i].rw))
        chk({vecs[i].name, " data"}, 64'(oDregDATA), 64'(vecs[i].expData));
      chk({vecs[i].name, " req off"}, 64'(oDReq), 64'd0);
      step();
      chk({vecs[i].name, " pulse"}, 64'(oValid), 64'd0);
      chk({vecs[i].name, " mis pulse"}, 64'(oMisalign), 64'd0);
    end

    // LB with three idle WAIT cycles before the ack
    iValid = 1'b1; iMEM = 1'b1; iRW = 1'b1; iFUNCT3 = 3'b000; iADDR = 32'h1003; iDregADDR = 5'd10;
    step();
    iValid = 1'b0; iMEM = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("lbwait stall", 64'(oStall), 64'd1);
      chk("lbwait req", 64'(oDReq), 64'd1);
      chk("lbwait be", 64'(oDBe), 64'h8);
      chk("lbwait valid", 64'(oValid), 64'd0);
      step();
    end
    iDAck = 1'b1; iDRdata = 32'h80FFFFFF;
    step();
    iDAck = 1'b0;
    chk("lbwait done", 64'(oValid), 64'd1);
    chk("lbwait data", 64'(oDregDATA), 64'hFFFFFF80);
    chk("lbwait rd", 64'(oDregADDR), 64'd10);
    step();

    // Ack while idle is ignored
    iDAck = 1'b1;
    step();
    iDAck = 1'b0;
    chk("idle ack valid", 64'(oValid), 64'd0);
    chk("idle ack req", 64'(oDReq), 64'd0);

    // Reset two cycles into WAIT, then a stale ack
    iValid = 1'b1; iMEM = 1'b1; iRW = 1'b1; iFUNCT3 = 3'b010; iADDR = 32'h1000; iDregADDR = 5'd11;
    step();
    iValid = 1'b0; iMEM = 1'b0;
    step(); step();
    chk("pre-rst req", 64'(oDReq), 64'd1);
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    chk("rst wait req", 64'(oDReq), 64'd0);
    chk("rst wait be", 64'(oDBe), 64'd0);
    chk("rst wait addr", 64'(oDAddr), 64'd0);
    chk("rst wait stall", 64'(oStall), 64'd0);
    iDAck = 1'b1; iDRdata = 32'h12345678;
    step();
    iDAck = 1'b0;
    chk("stale ack valid", 64'(oValid), 64'd0);
    chk("stale ack rd", 64'(oDregADDR), 64'd0);
    chk("stale ack req", 64'(oDReq), 64'd0);

    run64("lwu64", 3'b110, 32'h0C, 64'hFFFFFFFF_00000000, 8'hF0, 32'h08, 64'h00000000_FFFFFFFF);
    run64("lw64", 3'b010, 32'h08, 64'h00000000_80000000, 8'h0F, 32'h08, 64'hFFFFFFFF_80000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
